// File: rtl/regfile_pkg.sv
// Shared constants and lane-merge helper for the parametrised register file.
// Imported by the top module and the scoreboard.
package regfile_pkg;

    localparam logic [1:0] WR_FULL    = 2'b00;
    localparam logic [1:0] WR_LO_HALF = 2'b01;
    localparam logic [1:0] WR_HI_HALF = 2'b10;
    localparam logic [1:0] WR_LO_BYTE = 2'b11;

    // Widest register the merge helper can handle.
    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] word_t;

    // Merge write data into the old word for the selected lane.
    // dw is the real register width.
    // Partial modes always source from the low bits of data.
    function automatic word_t lane_merge(
        input word_t      old,
        input word_t      data,
        input logic [1:0] mode,
        input int         dw
    );
        word_t full_m;
        word_t lo_m;
        word_t m;
        word_t src;
        int    h;
        h      = dw / 2;
        full_m = (dw >= MAX_W) ? '1
                               : ((word_t'(1) << dw) - word_t'(1));
        lo_m   = (word_t'(1) << h) - word_t'(1);
        m      = full_m;
        src    = data;
        unique case (mode)
            WR_FULL: begin
                m   = full_m;
                src = data;
            end
            WR_LO_HALF: begin
                m   = lo_m;
                src = data;
            end
            WR_HI_HALF: begin
                m   = full_m & ~lo_m;
                src = (data & lo_m) << h;
            end
            WR_LO_BYTE: begin
                m   = word_t'(8'hFF);
                src = data;
            end
        endcase
        return (old & ~m) | (src & m);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer
// and raises the read stall when a requested source is still busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reg_reset,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic                     rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic                     rd_stall_o,
    output logic [(1<<ADDR_W)-1:0]   busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [NUM_RD-1:0] hazard;

    // Next busy vector: a write clears, a reserve sets and wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (rsv_en_i) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port hazard; a same-cycle write to the source resolves it.
    always_comb begin
        hazard = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            hazard[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]]
                      & ~(wr_en_i
                          & (wr_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]));
        end
    end

    assign rd_stall_o = rd_en_i & (|hazard);
    assign busy_o     = busy_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with lane-masked writes, write-to-read
// forwarding, a one-cycle read pipeline and a busy-bit scoreboard.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reg_reset,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic                     rd_stall,
    output logic                     rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [1:0]               wr_mode,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        wr_merged;
    logic                     wr_ok;
    logic                     rd_fire;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic                     rd_valid_q;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reg_reset  (reg_reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_stall_o (rd_stall),
        .busy_o     (busy)
    );

    assign wr_merged = DATA_W'(lane_merge(word_t'(regs_q[wr_addr]),
                                          word_t'(wr_data),
                                          wr_mode, DATA_W));

    assign wr_ok   = wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));
    assign rd_fire = rd_en & ~rd_stall;

    // Register storage with lane-merged write.
    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_merged;
        end
    end

    // Per-port read value, forwarding the merged word on an address hit.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((ZERO_REG != 0)
                && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
                rd_data_d[k*DATA_W +: DATA_W] = '0;
            end else if (wr_ok
                && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
                rd_data_d[k*DATA_W +: DATA_W] = wr_merged;
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] =
                    regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Read pipeline: capture on an accepted request, hold otherwise.
    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the processor's register file.
- Configurable data width, register count and number of read ports.
- Adds lane-masked writes (full / low-half / high-half / low-byte), same-cycle write-to-read forwarding and a busy-bit scoreboard that stalls reads of registers with an outstanding producer.
- Sits between decode (read/reserve requests) and writeback (write port) in the datapath.

Parameters:
- DATA_W, 32: register width in bits; must be even and ≥16.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- NUM_RD, 3: number of read ports, 1..4.
- ZERO_REG, 1: 1 means register 0 reads as zero and ignores writes and reservations.

Ports:
- clk  in  1  clock, rising edge.
- reg_reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request; all ports are sampled together.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k is at slice [k*ADDR_W +: ADDR_W].
- rd_stall  out  1  combinational; high when the current read request cannot be accepted.
- rd_valid  out  1  registered; high for one cycle when rd_data is updated.
- rd_data  out  NUM_RD*DATA_W  registered read data; port k is at slice [k*DATA_W +: DATA_W].
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_mode  in  2  lane select: 00 full, 01 low half, 10 high half, 11 low byte.
- wr_data  in  DATA_W  write data; partial modes source from the low bits.
- rsv_en  in  1  reserve strobe; marks a destination as busy.
- rsv_addr  in  ADDR_W  address to reserve.
- busy  out  2**ADDR_W  scoreboard bits, registered.

Behaviour:
- Reset: asynchronous, active-high, on reg_reset.
  - Every register, rd_data, rd_valid and busy go to 0.
  - Reset asserted mid-operation discards any in-flight read; rd_valid is 0 the cycle after release.
- Write, at posedge clk when wr_en, merged into the old value:
  - Mode 00: whole word = wr_data.
  - Mode 01: [DATA_W/2-1:0] = wr_data[DATA_W/2-1:0]; upper half unchanged.
  - Mode 10: [DATA_W-1:DATA_W/2] = wr_data[DATA_W/2-1:0]; lower half unchanged.
  - Mode 11: [7:0] = wr_data[7:0]; all other bits unchanged.
  - A write also clears busy[wr_addr].
  - With ZERO_REG=1, writes to address 0 are ignored and busy[0] stays 0.
- Reserve, at posedge when rsv_en: sets busy[rsv_addr].
  - If rsv and wr hit the same address in one cycle, the data write happens and busy ends set: reserve wins.
- Stall (combinational):
  - rd_stall = rd_en AND (some port k has busy[addr_k]=1 AND NOT (wr_en AND wr_addr==addr_k)).
  - A same-cycle write resolves the dependency, so no stall.
- Read:
  - When rd_en AND NOT rd_stall at a posedge, each rd_data slice gets its register value, with rd_valid=1 in the next cycle. Latency is 1.
  - Forwarding: if wr_en and wr_addr==addr_k in the same cycle, port k captures the merged post-write value, not the stale one.
  - With ZERO_REG=1, address 0 returns 0.
  - Otherwise (no request, or stalled): rd_data holds its previous value and rd_valid=0.
  - The requester must hold rd_en and rd_addr stable while rd_stall is high.
- Duplicate read addresses across ports are legal and return identical data.
- Back-to-back reads every cycle are supported; there is no bubble.

Decomposition:
- Shared package regfile_pkg:
  - WR_FULL, WR_LO_HALF, WR_HI_HALF, WR_LO_BYTE (2-bit constants).
  - Merge function lane_merge(old, data, mode).
- One natural sub-module, regfile_scoreboard:
  - Holds the busy vector with its set/clear priority.
  - Produces the per-port hazard and the rd_stall signal.
- Storage, forwarding and the read pipeline stay in the top module.

Test Plan:
1. Reset, then write 0xDEADBEEF full to r5, then read r5/r0/r5 → next cycle rd_data = {0xDEADBEEF, 0, 0xDEADBEEF}, rd_valid=1. Also write 0x1234 to r0 and read r0 → returns 0.
2. Lane modes on r7:
   - Write full 0x11223344.
   - Mode 01 with 0x0000AAAA → r7 = 0x1122AAAA.
   - Mode 10 with 0x0000BBBB → r7 = 0xBBBBAAAA.
   - Mode 11 with 0x000000CC → r7 = 0xBBBBAACC.
3. Forwarding: r3=0x0F0F0F0F; same cycle write r3 mode 11 data 0x55 and read r3 → rd_data = 0x0F0F0F55, with no stall.
4. Scoreboard stall:
   - rsv r9, then rd_en on r9 → rd_stall=1 and rd_valid stays 0 for 3 cycles.
   - Write r9=0x77 → rd_stall drops in the write cycle, and next cycle rd_data = 0x77, busy[9]=0.
   - Also: rsv and wr on r9 in the same cycle → busy[9]=1 and the data is written.
5. Reset mid-read: issue a read, assert reg_reset asynchronously before the next edge → rd_valid=0, rd_data=0, busy all 0, and register reads return 0 afterwards.
6. Parameter sweep DATA_W=16, ADDR_W=3, NUM_RD=1, ZERO_REG=0:
   - Mode 10 on r0 with 0x00AB → r0 = 0xAB00.
   - Address 7 wraps correctly.
   - All 8 registers are independently writable.
